call_return_ctrl: RTL and testbench
===================================

Name: call_return_ctrl

Overview:
- Program-flow controller for the basic CPU. Owns the 10-bit PC.
- Decodes call/ret/reti/jump/irq events and drives the push/pop side of the 16-word return-address stack.
- Tracks stack depth and traps overflow and underflow.
- Sits between the instruction decoder and the return-address stack; the stack's top-of-stack output feeds back into this block.

Parameters:
- PC_W, 10, PC and address width.
- DEPTH, 15, usable stack entries (16-word stack; entry 0 is never written).
- RESET_PC, 10'd0, PC after reset.
- IRQ_VECTOR, 10'h3F0, ISR entry address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  freeze PC, state and depth; forces push=pop=0
- jump  in  1  unconditional jump to target
- call  in  1  subroutine call to target
- ret  in  1  return from subroutine
- reti  in  1  return from interrupt
- irq  in  1  interrupt request, level
- target  in  PC_W  jump/call destination
- stack_top  in  PC_W  combinational top-of-stack from the return-address stack
- pc  out  PC_W  current PC, registered
- push  out  1  stack push strobe, combinational
- pop  out  1  stack pop strobe, combinational
- push_data  out  PC_W  value to push; the stack stores push_data+1
- in_isr  out  1  high while in the ISR state
- fault  out  1  sticky stack fault
- depth  out  5  current stack occupancy, 0..DEPTH

Behaviour:
- Reset values: pc=RESET_PC, state=RUN, depth=0, in_isr=0, fault=0.
- push, pop and push_data are all forced to 0 while reset is high.
- States:
  - RUN: normal execution.
  - ISR: inside the interrupt routine; in_isr=1.
  - FAULT: terminal; fault=1.
- Per-cycle priority when not stalled: irq (RUN only) > reti > ret > call > jump > sequential.
- irq in RUN:
  - push=1, push_data=pc-1 (mod 2^PC_W), so the stored return address is pc and the pre-empted instruction re-executes.
  - Next cycle: pc=IRQ_VECTOR, depth+1, state -> ISR.
  - Any other event in the same cycle is discarded.
- irq in ISR or FAULT: ignored; no nesting.
- reti in ISR: pop=1; next cycle pc=stack_top, depth-1, state -> RUN.
- reti in RUN: state -> FAULT.
- ret (RUN or ISR): pop=1; next cycle pc=stack_top, depth-1.
- call: push=1, push_data=pc; next cycle pc=target, depth+1.
- jump: next cycle pc=target.
- No event: next cycle pc=pc+1, wrapping 0x3FF -> 0x000.
- Latency: every event updates pc on the next clk edge. push/pop are valid in the same cycle as the event and are sampled by the stack on that edge.
- Overflow: push requested with depth==DEPTH -> push suppressed, pc held, state -> FAULT.
- Underflow: pop requested with depth==0 -> pop suppressed, pc held, state -> FAULT.
- FAULT state: pc frozen, push=pop=0, all inputs ignored; only reset exits.
- stall=1 overrides everything: no strobes, no state change, even with irq pending.
- Reset asserted mid-ISR or mid-call clears state and depth immediately. The stack keeps its own contents; depth restarts at 0 and is authoritative.
- Multiple decode strobes in one cycle are legal; priority resolves them.

Decomposition:
- Shared package holds:
  - state encoding: ST_RUN=2'd0, ST_ISR=2'd1, ST_FAULT=2'd2;
  - PC_W, DEPTH;
  - IRQ_VECTOR default.
- One natural sub-module, depth_tracker: an up/down counter with saturation checks that outputs can_push and can_pop.

Test Plan:
- Reset then 4 idle cycles -> pc 0,1,2,3,4; push=pop=0; depth=0.
- Call at pc=0x005 with target=0x100 -> push=1, push_data=0x005 that cycle; next pc=0x100, depth=1. Later ret with stack_top=0x006 -> pop=1; next pc=0x006, depth=0.
- irq at pc=0x020 while call also high -> push_data=0x01F, call ignored; next pc=0x3F0, in_isr=1. irq held during ISR -> no push. reti with stack_top=0x020 -> pc=0x020, in_isr=0.
- 15 nested calls then a 16th call -> 16th gives push=0, fault=1, pc frozen. Reset -> fault=0, pc=0.
- ret with depth=0 -> pop=0, fault=1. Separately, reti in RUN -> fault=1.
- stall high during call/irq at pc=0x040 -> push=0, pc stays 0x040. Releasing stall -> the event executes normally.

Source files
------------

// File: rtl/call_return_ctrl_pkg.sv
// Shared definitions for the program-flow controller: FSM encoding and default widths.
package call_return_ctrl_pkg;

    localparam int unsigned PC_W_DEF    = 10;
    localparam int unsigned DEPTH_DEF   = 15;
    localparam int unsigned DEPTH_W     = 5;
    localparam logic [PC_W_DEF-1:0] IRQ_VECTOR_DEF = 10'h3F0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ISR   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/call_return_ctrl_depth_tracker.sv
// Return-stack occupancy counter; reports whether a push or pop can be honoured.
module call_return_ctrl_depth_tracker
    import call_return_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               can_push_c_o,
    output logic               can_pop_c_o
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign can_push_c_o = (depth_q < DEPTH_W'(DEPTH));
    assign can_pop_c_o  = (depth_q != '0);

    // Saturating up/down step; requests that would leave 0..DEPTH are dropped.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && can_push_c_o) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i && !inc_i && can_pop_c_o) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth_o = depth_q;

endmodule

// File: rtl/call_return_ctrl.sv
// Program-flow controller: owns the PC, resolves irq/reti/ret/call/jump and drives the return stack.
module call_return_ctrl
    import call_return_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEF,
    parameter int unsigned     DEPTH      = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(IRQ_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic                reti,
    input  logic                irq,
    input  logic [PC_W-1:0]     target,
    input  logic [PC_W-1:0]     stack_top,
    output logic [PC_W-1:0]     pc,
    output logic                push,
    output logic                pop,
    output logic [PC_W-1:0]     push_data,
    output logic                in_isr,
    output logic                fault,
    output logic [DEPTH_W-1:0]  depth
);

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            in_isr_q;
    logic            fault_q;

    logic            push_c;
    logic            pop_c;
    logic [PC_W-1:0] push_data_c;
    logic            can_push_c;
    logic            can_pop_c;

    call_return_ctrl_depth_tracker #(
        .DEPTH (DEPTH)
    ) u_depth (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (push_c),
        .dec_i        (pop_c),
        .depth_o      (depth),
        .can_push_c_o (can_push_c),
        .can_pop_c_o  (can_pop_c)
    );

    // Event decode in priority order; a blocked push/pop freezes the PC and traps.
    always_comb begin
        push_c      = 1'b0;
        pop_c       = 1'b0;
        push_data_c = '0;
        pc_d        = pc_q;
        state_d     = state_q;

        if (!reset && !stall) begin
            case (state_q)
                ST_RUN, ST_ISR: begin
                    if (irq && (state_q == ST_RUN)) begin
                        if (can_push_c) begin
                            push_c      = 1'b1;
                            push_data_c = pc_q - PC_W'(1);
                            pc_d        = IRQ_VECTOR;
                            state_d     = ST_ISR;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else if (reti) begin
                        if ((state_q == ST_ISR) && can_pop_c) begin
                            pop_c   = 1'b1;
                            pc_d    = stack_top;
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else if (ret) begin
                        if (can_pop_c) begin
                            pop_c = 1'b1;
                            pc_d  = stack_top;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else if (call) begin
                        if (can_push_c) begin
                            push_c      = 1'b1;
                            push_data_c = pc_q;
                            pc_d        = target;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else if (jump) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                default: begin
                    pc_d    = pc_q;
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // FSM with registered status outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            in_isr_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            in_isr_q <= (state_d == ST_ISR);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    assign pc        = pc_q;
    assign push      = push_c;
    assign pop       = pop_c;
    assign push_data = push_data_c;
    assign in_isr    = in_isr_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed vector bench for call_return_ctrl: table of per-cycle stimulus and expectations.
module tb_call_return_ctrl;

    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_JUMP  = 6'b000001;
    localparam logic [5:0] E_CALL  = 6'b000010;
    localparam logic [5:0] E_RET   = 6'b000100;
    localparam logic [5:0] E_RETI  = 6'b001000;
    localparam logic [5:0] E_IRQ   = 6'b010000;
    localparam logic [5:0] E_STALL = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, jump, call, ret, reti, irq;
    logic [9:0] target, stack_top;
    logic [9:0] pc, push_data;
    logic       push, pop, in_isr, fault;
    logic [4:0] depth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_return_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .reti      (reti),
        .irq       (irq),
        .target    (target),
        .stack_top (stack_top),
        .pc        (pc),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .in_isr    (in_isr),
        .fault     (fault),
        .depth     (depth)
    );

    typedef struct {
        logic [5:0] ev;
        logic [9:0] tgt;
        logic [9:0] top;
        logic [9:0] pc;
        logic       push;
        logic       pop;
        logic [9:0] pdata;
        logic [4:0] depth;
        logic       isr;
        logic       flt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [5:0] ev, input logic [9:0] tgt, input logic [9:0] top,
                                input logic [9:0] epc, input logic epush, input logic epop,
                                input logic [9:0] epd, input logic [4:0] ed, input logic eisr,
                                input logic eflt);
        vec_t v;
        v.ev = ev; v.tgt = tgt; v.top = top; v.pc = epc; v.push = epush; v.pop = epop;
        v.pdata = epd; v.depth = ed; v.isr = eisr; v.flt = eflt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] ev, input logic [9:0] tgt, input logic [9:0] top);
        {stall, irq, reti, ret, call, jump} = ev;
        target    = tgt;
        stack_top = top;
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v.ev, v.tgt, v.top);
        #1;
        chk({tag, " pc"},     32'(pc),     32'(v.pc));
        chk({tag, " push"},   32'(push),   32'(v.push));
        chk({tag, " pop"},    32'(pop),    32'(v.pop));
        chk({tag, " depth"},  32'(depth),  32'(v.depth));
        chk({tag, " in_isr"}, 32'(in_isr), 32'(v.isr));
        chk({tag, " fault"},  32'(fault),  32'(v.flt));
        if (v.push) chk({tag, " push_data"}, 32'(push_data), 32'(v.pdata));
        @(negedge clk);
    endtask

    // Asynchronous reset pulse checked before any rising edge.
    task automatic reset_pulse(input string tag);
        drive(E_CALL, 10'h155, 10'h2AA);
        reset = 1'b1;
        #1;
        chk({tag, " rst pc"},        32'(pc),        32'h0);
        chk({tag, " rst depth"},     32'(depth),     32'h0);
        chk({tag, " rst fault"},     32'(fault),     32'h0);
        chk({tag, " rst in_isr"},    32'(in_isr),    32'h0);
        chk({tag, " rst push"},      32'(push),      32'h0);
        chk({tag, " rst push_data"}, 32'(push_data), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(E_NONE,          10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        tbl[1]  = mk(E_NONE,          10'h000, 10'h000, 10'h001, 0, 0, 10'h000, 0, 0, 0);
        tbl[2]  = mk(E_NONE,          10'h000, 10'h000, 10'h002, 0, 0, 10'h000, 0, 0, 0);
        tbl[3]  = mk(E_NONE,          10'h000, 10'h000, 10'h003, 0, 0, 10'h000, 0, 0, 0);
        tbl[4]  = mk(E_NONE,          10'h000, 10'h000, 10'h004, 0, 0, 10'h000, 0, 0, 0);
        tbl[5]  = mk(E_CALL,          10'h100, 10'h000, 10'h005, 1, 0, 10'h005, 0, 0, 0);
        tbl[6]  = mk(E_NONE,          10'h000, 10'h000, 10'h100, 0, 0, 10'h000, 1, 0, 0);
        tbl[7]  = mk(E_RET,           10'h000, 10'h006, 10'h101, 0, 1, 10'h000, 1, 0, 0);
        tbl[8]  = mk(E_NONE,          10'h000, 10'h000, 10'h006, 0, 0, 10'h000, 0, 0, 0);
        tbl[9]  = mk(E_JUMP,          10'h020, 10'h000, 10'h007, 0, 0, 10'h000, 0, 0, 0);
        tbl[10] = mk(E_IRQ | E_CALL,  10'h123, 10'h000, 10'h020, 1, 0, 10'h01F, 0, 0, 0);
        tbl[11] = mk(E_IRQ,           10'h000, 10'h000, 10'h3F0, 0, 0, 10'h000, 1, 1, 0);
        tbl[12] = mk(E_IRQ,           10'h000, 10'h000, 10'h3F1, 0, 0, 10'h000, 1, 1, 0);
        tbl[13] = mk(E_RETI,          10'h000, 10'h020, 10'h3F2, 0, 1, 10'h000, 1, 1, 0);
        tbl[14] = mk(E_NONE,          10'h000, 10'h000, 10'h020, 0, 0, 10'h000, 0, 0, 0);
        tbl[15] = mk(E_JUMP,          10'h040, 10'h000, 10'h021, 0, 0, 10'h000, 0, 0, 0);
        tbl[16] = mk(E_STALL | E_CALL, 10'h200, 10'h000, 10'h040, 0, 0, 10'h000, 0, 0, 0);
        tbl[17] = mk(E_STALL | E_IRQ, 10'h200, 10'h000, 10'h040, 0, 0, 10'h000, 0, 0, 0);
        tbl[18] = mk(E_CALL,          10'h200, 10'h000, 10'h040, 1, 0, 10'h040, 0, 0, 0);
        tbl[19] = mk(E_NONE,          10'h000, 10'h000, 10'h200, 0, 0, 10'h000, 1, 0, 0);
        tbl[20] = mk(E_RET,           10'h000, 10'h041, 10'h201, 0, 1, 10'h000, 1, 0, 0);
        tbl[21] = mk(E_NONE,          10'h000, 10'h000, 10'h041, 0, 0, 10'h000, 0, 0, 0);
        tbl[22] = mk(E_RET,           10'h000, 10'h155, 10'h042, 0, 0, 10'h000, 0, 0, 0);
        tbl[23] = mk(E_NONE,          10'h000, 10'h000, 10'h042, 0, 0, 10'h000, 0, 0, 1);
        tbl[24] = mk(E_CALL,          10'h300, 10'h000, 10'h042, 0, 0, 10'h000, 0, 0, 1);
        tbl[25] = mk(E_IRQ,           10'h000, 10'h000, 10'h042, 0, 0, 10'h000, 0, 0, 1);

        // Power-on reset with a call strobe asserted: strobes must stay low.
        reset = 1'b1;
        drive(E_NONE, 10'h000, 10'h000);
        @(negedge clk);
        reset_pulse("por");

        for (int i = 0; i < 26; i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // reti while in RUN traps.
        reset_pulse("r1");
        run_vec("reti_run",   mk(E_RETI, 10'h000, 10'h077, 10'h000, 0, 0, 10'h000, 0, 0, 0));
        run_vec("reti_fault", mk(E_NONE, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 1));

        // Fill the stack, then overflow on the 16th call.
        reset_pulse("r2");
        for (int i = 0; i < 15; i++) begin
            logic [9:0] cur;
            cur = (i == 0) ? 10'h000 : 10'(10'h100 + i - 1);
            run_vec($sformatf("nest%0d", i),
                    mk(E_CALL, 10'(10'h100 + i), 10'h000, cur, 1, 0, cur, 5'(i), 0, 0));
        end
        run_vec("ovf_call",  mk(E_CALL, 10'h3AA, 10'h000, 10'h10E, 0, 0, 10'h000, 15, 0, 0));
        run_vec("ovf_fault", mk(E_NONE, 10'h000, 10'h000, 10'h10E, 0, 0, 10'h000, 15, 0, 1));
        run_vec("ovf_frz",   mk(E_JUMP, 10'h011, 10'h000, 10'h10E, 0, 0, 10'h000, 15, 0, 1));

        // irq at pc 0 wraps the pushed value; reset mid-ISR clears state.
        reset_pulse("r3");
        run_vec("irq_wrap", mk(E_IRQ,  10'h000, 10'h000, 10'h000, 1, 0, 10'h3FF, 0, 0, 0));
        run_vec("in_isr",   mk(E_NONE, 10'h000, 10'h000, 10'h3F0, 0, 0, 10'h000, 1, 1, 0));
        reset_pulse("r4");

        // PC wraps from 0x3FF to 0x000.
        run_vec("j3ff",  mk(E_JUMP, 10'h3FF, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0));
        run_vec("at3ff", mk(E_NONE, 10'h000, 10'h000, 10'h3FF, 0, 0, 10'h000, 0, 0, 0));
        run_vec("wrap0", mk(E_NONE, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
